// File: rtl/ex_wb_stage.sv
// Write-back stage: 2-entry in-order buffer draining EX results into the RF port and CPSR; `WB_FORWARD_EN adds a head/tail forward port.
// Latency: an entry accepted at edge N is on rf_* in cycle N+1 and commits at edge N+1 unless wb_stall.
// Backpressure: ex_ready drops only when both entries are held, decoded from registered state (no wb_stall path).
module ex_wb_stage #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [DATA_W:0]   ex_result,
   input  logic [2:0]        ex_dest_reg,
   input  logic              ex_reg_we,
   input  logic [3:0]        ex_flags,
   input  logic [3:0]        ex_flags_mask,
   input  logic              wb_stall,
   output logic              rf_we,
   output logic [2:0]        rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [3:0]        cpsr,
   input  logic [3:0]        br_cond,
   output logic              br_taken,
   output logic              flags_pending,
   output logic              fwd_valid,
   output logic [2:0]        fwd_reg,
   output logic [DATA_W-1:0] fwd_data
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [2:0]        dest;
      logic              reg_we;
      logic [3:0]        flags;
      logic [3:0]        mask;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   localparam int unused_depth = DEPTH;

   state_t state;
   entry_t head;
   entry_t tail;
   entry_t in_ent;
   logic   head_vld;
   logic   push;
   logic   pop;
   logic   unused_carry;

   // The carry/overflow bit only feeds EX flag generation; it is never written back.
   assign unused_carry = ex_result[DATA_W];

   assign in_ent   = '{data: ex_result[DATA_W-1:0], dest: ex_dest_reg, reg_we: ex_reg_we,
                       flags: ex_flags, mask: ex_flags_mask};
   assign head_vld = (state != EMPTY);
   assign ex_ready = (state != FULL);
   assign push     = ex_valid & ex_ready;
   assign pop      = head_vld & ~wb_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         head  <= '0;
         tail  <= '0;
         cpsr  <= 4'b0000;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  head  <= in_ent;
                  state <= ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  head <= in_ent;
               end else if (push) begin
                  tail  <= in_ent;
                  state <= FULL;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head  <= tail;
                  state <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
         // Flags commit with the head entry so the CPSR is always precise.
         if (pop) begin
            cpsr <= (cpsr & ~head.mask) | (head.flags & head.mask);
         end
      end
   end

   assign rf_we         = pop & head.reg_we;
   assign rf_waddr      = head_vld ? head.dest : 3'd0;
   assign rf_wdata      = head_vld ? head.data : '0;
   assign flags_pending = (head_vld & (|head.mask)) | ((state == FULL) & (|tail.mask));

   always_comb begin
      logic n, c, z, v;
      n = cpsr[3];
      c = cpsr[2];
      z = cpsr[1];
      v = cpsr[0];
      br_taken = 1'b0;
      case (br_cond)
         4'b0000: br_taken = z;
         4'b0001: br_taken = ~z;
         4'b0010: br_taken = c;
         4'b0011: br_taken = ~c;
         4'b0100: br_taken = n;
         4'b0101: br_taken = ~n;
         4'b0110: br_taken = v;
         4'b0111: br_taken = ~v;
         4'b1000: br_taken = c & ~z;
         4'b1001: br_taken = ~(c & ~z);
         4'b1010: br_taken = (n == v);
         4'b1011: br_taken = (n != v);
         4'b1100: br_taken = ~z & (n == v);
         4'b1101: br_taken = ~(~z & (n == v));
         4'b1110: br_taken = 1'b1;
         default: br_taken = 1'b0;
      endcase
   end

`ifdef WB_FORWARD_EN
   logic tail_hit;
   // Youngest write to the head's register wins.
   assign tail_hit  = (state == FULL) & tail.reg_we & (tail.dest == head.dest);
   assign fwd_valid = head_vld & head.reg_we;
   assign fwd_reg   = fwd_valid ? head.dest : 3'd0;
   assign fwd_data  = !fwd_valid ? '0 : (tail_hit ? tail.data : head.data);
`else
   assign fwd_valid = 1'b0;
   assign fwd_reg   = 3'd0;
   assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: a queue of expected RF writes is filled at accept time and drained by a monitor.
module tb_ex_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_ready;
   logic [32:0] ex_result;
   logic [2:0]  ex_dest_reg;
   logic        ex_reg_we;
   logic [3:0]  ex_flags;
   logic [3:0]  ex_flags_mask;
   logic        wb_stall;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [3:0]  cpsr;
   logic [3:0]  br_cond;
   logic        br_taken;
   logic        flags_pending;
   logic        fwd_valid;
   logic [2:0]  fwd_reg;
   logic [31:0] fwd_data;

   int          n_pass = 0;
   int          n_total = 0;
   logic [34:0] exp_q[$];

   always #5 clk = ~clk;

   ex_wb_stage #(.DATA_W(32), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
      .ex_dest_reg(ex_dest_reg), .ex_reg_we(ex_reg_we), .ex_flags(ex_flags),
      .ex_flags_mask(ex_flags_mask), .wb_stall(wb_stall),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .cpsr(cpsr), .br_cond(br_cond), .br_taken(br_taken),
      .flags_pending(flags_pending),
      .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every RF write strobe must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (rst_n && rf_we) begin
         if (exp_q.size() == 0) begin
            chk("rf_unexpected_write", {29'd0, rf_waddr, rf_wdata}, 64'hDEAD);
         end else begin
            chk("rf_write", {29'd0, rf_waddr, rf_wdata}, {29'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic send(input logic [32:0] res, input logic [2:0] dest, input logic we,
                       input logic [3:0] fl, input logic [3:0] mk);
      bit done = 0;
      ex_valid = 1'b1; ex_result = res; ex_dest_reg = dest;
      ex_reg_we = we; ex_flags = fl; ex_flags_mask = mk;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (ex_ready) begin
            if (we) exp_q.push_back({dest, res[31:0]});
            done = 1;
         end
         @(posedge clk); #1;
      end
      ex_valid = 1'b0;
      if (!done) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   logic [15:0] br_exp;

   initial begin
      rst_n = 1'b0; ex_valid = 1'b0; ex_result = '0; ex_dest_reg = '0; ex_reg_we = 1'b0;
      ex_flags = '0; ex_flags_mask = '0; wb_stall = 1'b0; br_cond = 4'b0000;
      cyc(2);
      @(negedge clk);
      chk("reset_ex_ready", ex_ready, 1);
      chk("reset_rf_we", rf_we, 0);
      chk("reset_cpsr", cpsr, 0);
      chk("reset_pending", flags_pending, 0);
      chk("reset_br_z", br_taken, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      cyc(1);

      // Single push, minimum latency.
      send(33'h0_0000_0005, 3'd3, 1'b1, 4'b0000, 4'b0000);
      @(negedge clk);
      chk("lat_rf_we", rf_we, 1);
      chk("lat_waddr", rf_waddr, 3);
      chk("lat_wdata", rf_wdata, 32'h5);
      @(posedge clk); #1;
      @(negedge clk);
      chk("single_drained", rf_we, 0);
      chk("single_cpsr", cpsr, 0);

      // Stall: two accepted, third blocked, then in-order drain.
      @(posedge clk); #1;
      wb_stall = 1'b1;
      send(33'h1_0000_0011, 3'd1, 1'b1, 4'b0000, 4'b0000);
      send(33'h0_0000_0022, 3'd2, 1'b1, 4'b0000, 4'b0000);
      ex_valid = 1'b1; ex_result = 33'h0_0000_0033; ex_dest_reg = 3'd4; ex_reg_we = 1'b1;
      ex_flags = 4'b0000; ex_flags_mask = 4'b0000;
      @(negedge clk);
      chk("full_ex_ready", ex_ready, 0);
      chk("full_stall_rf_we", rf_we, 0);
      @(posedge clk); #1;
      wb_stall = 1'b0;
      send(33'h0_0000_0033, 3'd4, 1'b1, 4'b0000, 4'b0000);
      cyc(2);
      @(negedge clk);
      chk("drain_ex_ready", ex_ready, 1);
      chk("drain_rf_we", rf_we, 0);

      // Push and pop in ONE: no drop, no duplicate.
      @(posedge clk); #1;
      send(33'h0_0000_00A1, 3'd5, 1'b1, 4'b0000, 4'b0000);
      send(33'h0_0000_00B2, 3'd6, 1'b1, 4'b0000, 4'b0000);
      @(negedge clk);
      chk("pp_second_waddr", rf_waddr, 6);
      chk("pp_second_wdata", rf_wdata, 32'hB2);
      cyc(2);

      // CPSR commit and condition evaluation.
      send(33'h0, 3'd0, 1'b0, 4'b1010, 4'b1111);
      send(33'h0, 3'd0, 1'b0, 4'b0101, 4'b0010);
      @(negedge clk);
      chk("cpsr_first", cpsr, 4'b1010);
      @(posedge clk); #1;
      @(negedge clk);
      chk("cpsr_second", cpsr, 4'b1000);
      br_exp = 16'h6A9A;
      for (int c = 0; c < 16; c++) begin
         @(posedge clk); #1;
         br_cond = c[3:0];
         @(negedge clk);
         chk($sformatf("br_cond_%0d", c), br_taken, br_exp[c]);
      end

      // Pending flags under stall; CPSR holds until commit.
      @(posedge clk); #1;
      br_cond = 4'b0100;
      wb_stall = 1'b1;
      send(33'h0, 3'd0, 1'b0, 4'b0111, 4'b0101);
      @(negedge clk);
      chk("pend_set", flags_pending, 1);
      chk("pend_old_cpsr", cpsr, 4'b1000);
      chk("pend_old_br", br_taken, 1);
      cyc(2);
      @(negedge clk);
      chk("pend_hold", flags_pending, 1);
      @(posedge clk); #1;
      wb_stall = 1'b0;
      @(negedge clk);
      chk("pend_commit_cycle", flags_pending, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("pend_clear", flags_pending, 0);
      chk("pend_new_cpsr", cpsr, 4'b1101);
      @(posedge clk); #1;
      br_cond = 4'b0110;
      @(negedge clk);
      chk("pend_new_br_v", br_taken, 1);

      // Forward port with head and tail both targeting r2.
      @(posedge clk); #1;
      wb_stall = 1'b1;
      send(33'h0_0000_0007, 3'd2, 1'b1, 4'b0000, 4'b0000);
      send(33'h0_0000_0009, 3'd2, 1'b1, 4'b0000, 4'b0000);
      @(negedge clk);
`ifdef WB_FORWARD_EN
      chk("fwd_valid", fwd_valid, 1);
      chk("fwd_reg", fwd_reg, 2);
      chk("fwd_data", fwd_data, 32'h9);
`else
      chk("fwd_valid_off", fwd_valid, 0);
      chk("fwd_data_off", fwd_data, 0);
`endif
      @(posedge clk); #1;
      wb_stall = 1'b0;
      cyc(3);

      // Reset while FULL drops both entries.
      wb_stall = 1'b1;
      send(33'h0_0000_0055, 3'd5, 1'b1, 4'b1111, 4'b1111);
      send(33'h0_0000_0066, 3'd6, 1'b1, 4'b0000, 4'b0000);
      @(negedge clk);
      chk("rst_pre_full", ex_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_q.delete();
      wb_stall = 1'b0;
      @(negedge clk);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_cpsr", cpsr, 0);
      chk("rst_pending", flags_pending, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(2);
      @(negedge clk);
      chk("rst_after_ready", ex_ready, 1);
      chk("rst_after_rf_we", rf_we, 0);
      chk("rst_after_cpsr", cpsr, 0);

      cyc(2);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ex_wb_stage.md
# ex_wb_stage

Write-back stage sitting directly downstream of the execute stage. It accepts one EX result per handshake into a 2-entry in-order buffer and drains it into the 3-bit-addressed register file write port, stalling when the port is busy. Flags are committed to the CPSR at drain time, so flag state stays precise. The stage resolves branch conditions against the committed CPSR and flags a hazard while flag writes are still in flight.

## Interface
Parameters:
- DATA_W, 32, register data width (result input is DATA_W+1 wide).
- DEPTH, 2, buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX presents a result this cycle.
- ex_ready  out  1  stage can accept a result.
- ex_result  in  33  EX result; bit 32 is the carry-out/overflow bit; [31:0] is written.
- ex_dest_reg  in  3  destination register.
- ex_reg_we  in  1  write the register file on commit.
- ex_flags  in  4  {N,C,Z,V} computed by EX.
- ex_flags_mask  in  4  per-bit CPSR write enable.
- wb_stall  in  1  register-file port busy this cycle.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  3  write address.
- rf_wdata  out  32  write data.
- cpsr  out  4  committed {N,C,Z,V}.
- br_cond  in  4  branch condition code.
- br_taken  out  1  condition true under committed CPSR.
- flags_pending  out  1  a buffered entry has a nonzero flag mask.
- fwd_valid  out  1  forwarding entry valid (see Configuration).
- fwd_reg  out  3  forwarded register.
- fwd_data  out  32  forwarded data.

## Operation
- The buffer has 2 entries: head and tail. States are EMPTY, ONE and FULL.
- An entry holds {result[31:0], dest, reg_we, flags, mask}. Entries with reg_we=0 still occupy a slot, because flag-only ops commit in order.
- push = ex_valid & ex_ready.
- pop = (state != EMPTY) & !wb_stall.
- ex_ready = (state != FULL). It is decoded from registered state only and has no combinational path from wb_stall.
- State transitions:
  - EMPTY: push → ONE.
  - ONE: push & !pop → FULL; pop & !push → EMPTY; push & pop → ONE, with the new entry becoming head.
  - FULL: pop → ONE, with tail moving to head. push cannot occur.
- Commit occurs on pop:
  - rf_we = pop & head.reg_we. rf_waddr and rf_wdata always show the head entry, and 0 when EMPTY.
  - At the same edge, cpsr[i] ← head.flags[i] for each i where head.mask[i]=1. Unmasked bits hold.
- br_taken is combinational from cpsr and br_cond, with N=cpsr[3], C=[2], Z=[1], V=[0]:
  - 0000 Z
  - 0001 !Z
  - 0010 C
  - 0011 !C
  - 0100 N
  - 0101 !N
  - 0110 V
  - 0111 !V
  - 1000 C&!Z
  - 1001 !(C&!Z)
  - 1010 N==V
  - 1011 N!=V
  - 1100 !Z&(N==V)
  - 1101 !(!Z&(N==V))
  - 1110 1
  - 1111 0
- flags_pending = OR over valid entries of |mask. A consumer must not trust br_taken while flags_pending=1.
- Reset, including mid-operation, drops all entries. State ← EMPTY, cpsr ← 4'b0000, all outputs 0 (ex_ready becomes 1 after reset).

## Timing
- Minimum latency: an entry accepted at edge N is presented on rf_* during cycle N+1 and written at edge N+1 if wb_stall=0.
- Throughput is 1 entry per cycle with wb_stall low.
- When wb_stall holds, the buffer accepts 2 entries, then ex_ready drops in the cycle after the second accept.
- A CPSR update becomes visible on cpsr and br_taken in the cycle after the committing edge.
- rf_* are combinational from registered head plus wb_stall. There is no register → ex_ready → ex_valid loop.

## Configuration
- WB_FORWARD_EN defined:
  - fwd_valid = head valid & head.reg_we.
  - fwd_reg and fwd_data come from the head, or from the tail if the tail is valid, writes to the same register and is younger (youngest wins).
- WB_FORWARD_EN undefined: fwd_valid, fwd_reg and fwd_data are tied to 0 and no forwarding mux is built.

## Test plan
- Reset then single push (result 0x0_0000_0005, dest 3, reg_we 1, mask 0), no stall → rf_we=1, waddr 3, wdata 0x5 one cycle later; cpsr stays 0000.
- Hold wb_stall, push 3 back-to-back → first two accepted, ex_ready=0 in the following cycle. Release stall → commits in order over 2 cycles, then ex_ready=1.
- Push flags 1010 with mask 1111, then flags 0101 with mask 0010 → cpsr 1010, then 1000. br_cond 0100 → taken; 0000 → not taken.
- Push with mask≠0 under stall → flags_pending=1 until the commit edge. br_taken still reflects the old CPSR.
- Simultaneous push and pop in ONE → state stays ONE; the new entry commits next cycle with no drop or duplicate.
- Assert rst_n low while FULL → rf_we=0, cpsr=0000, ex_ready=1 after release. With WB_FORWARD_EN, tail dest 2 data 0x9 over head dest 2 data 0x7 → fwd_data 0x9.
